// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: PC register, direct-mapped instruction cache and a
// line refill FSM delivering one registered instruction per cycle to decode.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_target,
  input  logic                      stall,
  output logic [31:0]               instruction,
  output logic                      inst_valid,
  output logic [ADDR_W-1:0]         pc,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ready,
  input  logic [32*LINE_WORDS-1:0]  mem_data,
  output logic                      dbg_state
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_W - OW - IW - 2;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] pc_out_d;
  logic              inst_valid_d;
  logic              fill_en;

  // Cache storage: only the valid bits carry a reset.
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [31:0]          fill_row [LINE_WORDS];

  logic [OW-1:0]     pc_off;
  logic [IW-1:0]     pc_idx;
  logic [TW-1:0]     pc_tag;
  logic              hit;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] line_base;
  logic [1:0]        unused_target_lsbs;

  assign pc_off      = pc_q[OW+1:2];
  assign pc_idx      = pc_q[OW+IW+1:OW+2];
  assign pc_tag      = pc_q[ADDR_W-1:OW+IW+2];
  assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign pc_inc      = pc_q + ADDR_W'(4);
  assign redirect_pc = {redirect_target[ADDR_W-1:2], 2'b00};
  assign line_base   = {pc_q[ADDR_W-1:OW+2], {(OW+2){1'b0}}};
  assign unused_target_lsbs = redirect_target[1:0];
  assign dbg_state   = (state_q == S_REFILL);

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_fill_split
    assign fill_row[g] = mem_data[g*32 +: 32];
  end

  // Refill handshake: mem_req is high for the whole of REFILL with mem_addr
  // held at the line base of pc_q; the cycle mem_ready is high the line is
  // taken, and mem_req drops on the following cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    instr_d      = instruction;
    pc_out_d     = pc;
    inst_valid_d = inst_valid;
    fill_en      = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;

    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect beats both stall and the sequential update.
          pc_d         = redirect_pc;
          inst_valid_d = 1'b0;
        end else if (hit) begin
          if (!stall) begin
            instr_d      = data_q[pc_idx][pc_off];
            pc_out_d     = pc_inc;
            inst_valid_d = 1'b1;
            pc_d         = pc_inc;
          end
        end else begin
          state_d = S_REFILL;
          if (!stall) begin
            inst_valid_d = 1'b0;
          end
        end
      end

      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_base;
        // A valid output held by stall survives only until decode takes it.
        if (!stall) begin
          inst_valid_d = 1'b0;
        end
        if (mem_ready) begin
          fill_en      = 1'b1;
          state_d      = S_RUN;
          pend_valid_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
          end
        end else if (redirect_valid) begin
          // The refill is never aborted; the newest target waits for it.
          pend_pc_d    = redirect_pc;
          pend_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      instruction  <= '0;
      pc           <= '0;
      inst_valid   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      instruction  <= instr_d;
      pc           <= pc_out_d;
      inst_valid   <= inst_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[pc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      data_q[pc_idx] <= fill_row;
      tag_q[pc_idx]  <= pc_tag;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a direct-mapped instruction cache, a miss-refill state machine and a valid/ready handshake toward a line-wide instruction memory. It holds the program counter, selects sequential or redirect (branch/jump) targets, and delivers one registered instruction per cycle to decode on a cache hit. It stalls cleanly on misses and on downstream back-pressure. It replaces the fixed-width fetch path with configurable line and cache geometry and adds reset, flush and stall support.

## Interface
- ADDR_W, 32, PC and memory address width (byte address; instructions are 32-bit, word-aligned)
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2 to 16
- NUM_LINES, 16, number of cache lines; power of two, 2 to 256
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  ADDR_W  new PC when redirect_valid=1; bits [1:0] are ignored
- stall  in  1  decode cannot accept; hold the outputs
- instruction  out  32  fetched instruction (registered)
- inst_valid  out  1  instruction and pc are valid this cycle
- pc  out  ADDR_W  fetched address + 4 (registered)
- mem_req  out  1  refill request; held until accepted
- mem_addr  out  ADDR_W  line-aligned refill address; low log2(LINE_WORDS)+2 bits are zero
- mem_ready  in  1  mem_data valid; completes the request
- mem_data  in  32*LINE_WORDS  refill line; word 0 is in bits [31:0]

## Operation
- Address split of pc_q: word offset is [OW+1:2], with OW = log2(LINE_WORDS). Index is the next log2(NUM_LINES) bits. Tag is the remaining upper bits.
- Storage: line data array, tag array and a valid bit per line. rst clears every valid bit. Data and tag arrays are not reset.
- Hit: valid[idx] && tag[idx]==tag(pc_q), evaluated combinationally from pc_q.
- FSM states:
  - RUN: performs hit lookup every cycle.
    - Hit && !stall: register instruction=line word, pc=pc_q+4, inst_valid=1; pc_q<=pc_q+4.
    - Hit && stall: hold all outputs and pc_q.
    - Miss: inst_valid<=0 unless stall (a held valid output stays until the stall drops); go to REFILL.
  - REFILL: mem_req=1, mem_addr=line base of pc_q; addr stays stable while waiting.
    - mem_ready=1: write the line, tag and valid=1 at idx; go to RUN.
    - mem_req may drop the cycle after acceptance.
- Redirect has priority over sequential update and over stall:
  - In RUN: pc_q<=redirect_target & ~3 and inst_valid<=0 (flushes the in-flight output).
  - In REFILL: target is latched in pend_pc with pend_valid=1. The refill completes and is never aborted. On the return to RUN, pc_q<=pend_pc and pend_valid<=0.
  - A later redirect overwrites pend_pc.
- PC arithmetic is modulo 2^ADDR_W; wrap from all-ones is permitted.
- A memory line fill writes all LINE_WORDS words at once; no partial fills.

## Timing
- Reset values: pc_q=RESET_PC, state=RUN, instruction=0, inst_valid=0, pc=0, mem_req=0, mem_addr=0, pend_valid=0, all valid bits 0.
- Hit latency: 1 cycle from pc_q to registered instruction. Throughput is 1 instruction per cycle on consecutive hits.
- Miss penalty: for mem_ready arriving N cycles after mem_req rises (N≥0), first valid instruction appears N+3 cycles after the miss cycle (RUN→REFILL, wait, RUN lookup, output register).
- rst during REFILL: return to RUN next edge, mem_req=0, discard the in-flight line. A late mem_ready is ignored.
- Simultaneous redirect and stall in RUN: redirect wins; inst_valid=0 next cycle.
- Simultaneous redirect and mem_ready in REFILL: the line is written; pc_q loads the redirect target on the same edge.
- stall never affects REFILL progress.

## Test plan
- Reset then cold start, RESET_PC=0, mem_ready after 2 cycles with line {0x4,0x3,0x2,0x1} → mem_req=1 with mem_addr=0x0. Then instructions 0x1,0x2,0x3,0x4 on consecutive cycles with pc=0x4,0x8,0xC,0x10, first valid 5 cycles after reset release.
- Loop back to 0x0 after the fill → all hits, zero mem_req, one instruction per cycle.
- stall held 3 cycles mid-stream → instruction/pc/inst_valid frozen. Resumes with the next word, none lost or duplicated.
- redirect_target=0x103 asserted during REFILL of line 0x40 → line 0x40 still filled. Next fetch is at 0x100 (miss, mem_addr=0x100). No instruction from 0x40 issued.
- Two addresses with the same index, different tags (0x000, 0x040 at LINE_WORDS=4, NUM_LINES=4) alternately → every access misses, and each refill overwrites the tag.
- rst asserted while mem_req=1, mem_ready pulsed the next cycle → no line written, all valids 0, pc_q=RESET_PC, inst_valid=0.
